// File: rtl/apb_cmd_master.sv
// APB initiator: turns single-beat register commands into APB transfers and returns
// read data / timeout status on a valid-ready response channel.
module apb_cmd_master #(
    parameter int unsigned AWIDTH  = 10,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              PCLK,
    input  logic              PRESET_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [7:0]        to_count,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    // Last wait-counter value before the abort fires; unused when TIMEOUT is 0.
    localparam logic [15:0] WaitLimit = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [AWIDTH-1:0]   paddr_q, paddr_d;
    logic [DWIDTH-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [7:0]          to_count_q, to_count_d;
    logic [15:0]         wait_cnt_q, wait_cnt_d;

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            state_q     <= StIdle;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            to_count_q  <= 8'd0;
            wait_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            to_count_q  <= to_count_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        to_count_d  = to_count_q;
        wait_cnt_d  = wait_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    if (req_write) begin
                        pwdata_d = req_wdata;
                    end
                    psel_d  = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                penable_d  = 1'b1;
                wait_cnt_d = 16'd0;
                state_d    = StAccess;
            end
            StAccess: begin
                // A ready slave on the limit cycle still counts as success.
                if (PREADY) begin
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = StResp;
                end else if (TIMEOUT != 0 && wait_cnt_q == WaitLimit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    if (to_count_q != 8'hFF) begin
                        to_count_d = to_count_q + 8'd1;
                    end
                    state_d = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign to_count  = to_count_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed latency/timeout/reset scenarios plus random traffic,
// all outputs compared each cycle against a transaction-level reference model.
module tb_apb_cmd_master;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          PCLK, PRESET_N;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, busy;
    logic [DW-1:0] rsp_rdata;
    logic [7:0]    to_count;
    logic          PSEL, PENABLE, PWRITE, PREADY;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;

    int n_checks = 0;
    int n_fail   = 0;

    apb_cmd_master #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET_N(PRESET_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy), .to_count(to_count),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one transaction at a time, tracked by how many ACCESS cycles elapsed.
    bit          m_busy        = 1'b0;
    int          m_acc         = 0;   // 0 = setup cycle, k = k-th access cycle
    logic        exp_psel      = 1'b0;
    logic        exp_penable   = 1'b0;
    logic        exp_pwrite    = 1'b0;
    logic [AW-1:0] exp_paddr   = '0;
    logic [DW-1:0] exp_pwdata  = '0;
    logic        exp_rsp_valid = 1'b0;
    logic [DW-1:0] exp_rdata   = '0;
    logic        exp_err       = 1'b0;
    logic [7:0]  exp_to_count  = 8'd0;

    always @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            m_busy <= 1'b0; m_acc <= 0;
            exp_psel <= 1'b0; exp_penable <= 1'b0; exp_pwrite <= 1'b0;
            exp_paddr <= '0; exp_pwdata <= '0;
            exp_rsp_valid <= 1'b0; exp_rdata <= '0; exp_err <= 1'b0;
            exp_to_count <= 8'd0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy <= 1'b1; m_acc <= 0; exp_psel <= 1'b1;
                exp_paddr <= req_addr; exp_pwrite <= req_write;
                if (req_write) exp_pwdata <= req_wdata;
            end
        end else if (exp_rsp_valid) begin
            if (rsp_ready) begin
                exp_rsp_valid <= 1'b0; m_busy <= 1'b0;
            end
        end else if (m_acc == 0) begin
            exp_penable <= 1'b1; m_acc <= 1;
        end else if (PREADY || m_acc == int'(TO)) begin
            exp_rsp_valid <= 1'b1; exp_psel <= 1'b0; exp_penable <= 1'b0;
            exp_err   <= !PREADY;
            exp_rdata <= (PREADY && !exp_pwrite) ? PRDATA : '0;
            if (!PREADY && exp_to_count != 8'hFF) exp_to_count <= exp_to_count + 8'd1;
        end else begin
            m_acc <= m_acc + 1;
        end
    end

    always @(negedge PCLK) begin
        chk("req_ready", 32'(req_ready), 32'(!m_busy));
        chk("busy",      32'(busy),      32'(m_busy));
        chk("PSEL",      32'(PSEL),      32'(exp_psel));
        chk("PENABLE",   32'(PENABLE),   32'(exp_penable));
        chk("PWRITE",    32'(PWRITE),    32'(exp_pwrite));
        chk("PADDR",     32'(PADDR),     32'(exp_paddr));
        chk("PWDATA",    PWDATA,         exp_pwdata);
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
        chk("rsp_rdata", rsp_rdata,      exp_rdata);
        chk("rsp_err",   32'(rsp_err),   32'(exp_err));
        chk("to_count",  32'(to_count),  32'(exp_to_count));
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Present a request for exactly one edge; returns in cycle N+1.
    task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        PRESET_N = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; PREADY = 1'b1; PRDATA = '0;
        repeat (3) tick();
        chk("reset PSEL", 32'(PSEL), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset to_count", 32'(to_count), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        PRESET_N = 1'b1;
        tick();

        // Zero-wait write
        do_req(1'b1, 10'h004, 32'hDEADBEEF);
        chk("wr N+1 PSEL", 32'(PSEL), 32'd1);
        chk("wr N+1 PENABLE", 32'(PENABLE), 32'd0);
        tick();
        chk("wr N+2 PENABLE", 32'(PENABLE), 32'd1);
        chk("wr N+2 PADDR", 32'(PADDR), 32'h004);
        chk("wr N+2 PWRITE", 32'(PWRITE), 32'd1);
        chk("wr N+2 PWDATA", PWDATA, 32'hDEADBEEF);
        tick();
        chk("wr N+3 rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr N+3 rsp_err", 32'(rsp_err), 32'd0);
        chk("wr N+3 rsp_rdata", rsp_rdata, 32'd0);
        tick();
        chk("wr N+4 req_ready", 32'(req_ready), 32'd1);

        // Read with 3 wait states
        PREADY = 1'b0; PRDATA = 32'h12345678;
        do_req(1'b0, 10'h3FC, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rd3w PENABLE", 32'(PENABLE), 32'd1);
            chk("rd3w PADDR", 32'(PADDR), 32'h3FC);
            if (i == 3) PREADY = 1'b1;
            else        PRDATA = 32'hFFFF0000 + 32'(i);
            if (i == 3) PRDATA = 32'h12345678;
        end
        tick();
        chk("rd3w rsp_rdata", rsp_rdata, 32'h12345678);
        chk("rd3w rsp_err", 32'(rsp_err), 32'd0);
        chk("rd3w PENABLE low", 32'(PENABLE), 32'd0);
        tick();

        // Timeout: 4 access cycles with PREADY stuck low
        PREADY = 1'b0;
        do_req(1'b0, 10'h055, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to PENABLE", 32'(PENABLE), 32'd1);
        end
        tick();
        chk("to PSEL", 32'(PSEL), 32'd0);
        chk("to PENABLE low", 32'(PENABLE), 32'd0);
        chk("to rsp_err", 32'(rsp_err), 32'd1);
        chk("to rsp_rdata", rsp_rdata, 32'd0);
        chk("to to_count", 32'(to_count), 32'd1);
        tick();

        // Boundary: PREADY rises on the 4th access cycle
        do_req(1'b0, 10'h066, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) begin PREADY = 1'b1; PRDATA = 32'hA5A50001; end
        end
        tick();
        chk("bnd rsp_err", 32'(rsp_err), 32'd0);
        chk("bnd rsp_rdata", rsp_rdata, 32'hA5A50001);
        chk("bnd to_count", 32'(to_count), 32'd1);
        tick();

        // Response backpressure with a new request waiting
        rsp_ready = 1'b0; PRDATA = 32'h0BADCAFE;
        do_req(1'b0, 10'h010, 32'h0);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h011; req_wdata = 32'hCAFEF00D;
        tick();
        tick();
        PRDATA = 32'h11111111;
        for (int i = 0; i < 5; i++) begin
            chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp rsp_rdata", rsp_rdata, 32'h0BADCAFE);
            chk("bp req_ready", 32'(req_ready), 32'd0);
            chk("bp busy", 32'(busy), 32'd1);
            if (i == 4) rsp_ready = 1'b1;
            tick();
        end
        chk("bp idle rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp idle PSEL", 32'(PSEL), 32'd0);
        tick();
        chk("bp next PSEL", 32'(PSEL), 32'd1);
        chk("bp next PADDR", 32'(PADDR), 32'h011);
        req_valid = 1'b0;
        repeat (3) tick();

        // Reset mid-ACCESS
        PREADY = 1'b0;
        do_req(1'b0, 10'h020, 32'h0);
        tick();
        chk("rst pre PENABLE", 32'(PENABLE), 32'd1);
        #2 PRESET_N = 1'b0;
        #1;
        chk("rst PSEL", 32'(PSEL), 32'd0);
        chk("rst PENABLE", 32'(PENABLE), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        tick();
        PRESET_N = 1'b1; PREADY = 1'b1; PRDATA = 32'h5A5A5A5A;
        tick();
        do_req(1'b0, 10'h100, 32'h0);
        tick();
        tick();
        chk("post-rst rsp_valid", 32'(rsp_valid), 32'd1);
        chk("post-rst rsp_rdata", rsp_rdata, 32'h5A5A5A5A);
        tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            int mode;
            mode = (c / 40) % 3;
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom);
            req_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            PRDATA    = $urandom;
            PREADY    = (mode == 0) ? 1'($urandom_range(0, 1)) : (mode == 1) ? 1'b0 : 1'b1;
            tick();
        end

        // Saturation: 300 back-to-back timeouts
        req_valid = 1'b1; rsp_ready = 1'b1; PREADY = 1'b0;
        repeat (300 * 7) tick();
        chk("sat to_count", 32'(to_count), 32'd255);
        req_valid = 1'b0;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB initiator for the control plane: turns single-beat register commands from a local requester (I2C/UART command parser, sequencer) into APB transfers.
- Drives the master-side APB signals; the parent wires them to the MASTER modport of the team's apb_if.
- Returns read data and a completion/timeout status through a valid/ready response channel.
- Protects the requester from a hung slave with a programmable PREADY timeout.

Parameters:
- AWIDTH, 10: APB address width.
- DWIDTH, 32: APB data width; legal values are 8, 16 and 32.
- TIMEOUT, 255: maximum number of ACCESS cycles with PREADY low before abort. 0 disables the timeout. Range 0..65535.

Ports:
- PCLK  in  1  bus clock; the only clock.
- PRESET_N  in  1  asynchronous, active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid and req_ready are both high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AWIDTH  target address.
- req_wdata  in  DWIDTH  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_rdata  out  DWIDTH  read data; 0 for writes and for timeouts.
- rsp_err  out  1  1 = transfer aborted by timeout.
- busy  out  1  high whenever state is not IDLE.
- to_count  out  8  saturating count of timeouts since reset.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  AWIDTH  APB address.
- PWDATA  out  DWIDTH  APB write data.
- PRDATA  in  DWIDTH  APB read data.
- PREADY  in  1  APB slave ready.

Behaviour:
- All outputs are registered except req_ready and busy, which decode state.
- Reset values: state IDLE; PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; to_count = 0; wait counter = 0. Reset is asynchronous: asserting PRESET_N low mid-transfer forces all of these immediately, with no response produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On handshake: register PADDR = req_addr, PWRITE = req_write, and PWDATA = req_wdata (writes only; reads keep the previous PWDATA). Set PSEL = 1 and go to SETUP.
- SETUP (one cycle):
  - PSEL = 1, PENABLE = 0.
  - Unconditionally go to ACCESS with PENABLE = 1 and the wait counter cleared.
- ACCESS:
  - PSEL = PENABLE = 1. PADDR, PWRITE and PWDATA are held stable.
  - PREADY = 1: capture PRDATA into rsp_rdata for reads (0 for writes), rsp_err = 0, drop PSEL/PENABLE, go to RESP.
  - PREADY = 0 and TIMEOUT != 0 and wait counter == TIMEOUT-1: abort. Drop PSEL/PENABLE, rsp_rdata = 0, rsp_err = 1, increment to_count (saturate at 255), go to RESP.
  - Otherwise increment the wait counter and stay.
  - PREADY high on the cycle the limit is reached: success wins, no error.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On handshake: rsp_valid = 0, go to IDLE.
  - req_ready stays 0 until the state is IDLE.
- Latency, zero-wait slave, request accepted at edge N:
  - PSEL high in cycle N+1.
  - PENABLE high in N+2.
  - rsp_valid high in N+3.
  - Earliest next acceptance at N+4 if rsp_ready is held high. Throughput is 1 transfer per 4 cycles.
- PREADY and PRDATA are ignored outside ACCESS.
- PSEL never rises without a preceding IDLE acceptance. PENABLE is never high without PSEL.
- After a transfer, PADDR/PWDATA/PWRITE retain their last values. Only PSEL/PENABLE return to 0.
- Exactly one outstanding command; there is no request buffering.
- Wait counter is 16 bits wide.

Test Plan:
- Zero-wait write: req addr=0x004, wdata=0xDEADBEEF, PREADY=1 → PSEL=1 at N+1; PENABLE=1 at N+2 with PADDR=0x004, PWRITE=1, PWDATA=0xDEADBEEF; rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x3FC, PREADY low for 3 ACCESS cycles then high with PRDATA=0x12345678 → PENABLE held 4 cycles, PADDR stable throughout; rsp_rdata=0x12345678, rsp_err=0.
- Timeout, TIMEOUT=4, PREADY stuck low → exactly 4 ACCESS cycles, then PSEL=PENABLE=0; rsp_err=1, rsp_rdata=0, to_count=1. Repeat 300 times → to_count saturates at 255.
- Boundary, TIMEOUT=4, PREADY rises on the 4th ACCESS cycle → success with rsp_err=0; to_count is unchanged.
- Response backpressure: rsp_ready low for 5 cycles → rsp_valid and rsp_rdata stable, req_ready=0, busy=1; a new req_valid is not accepted until 1 cycle after the rsp handshake.
- Reset mid-ACCESS: drive PRESET_N low while PENABLE=1 → PSEL, PENABLE and rsp_valid go to 0 asynchronously; after release, req_ready=1 and the next read completes normally.
